// File: rtl/vecmac_accum.sv
// ============================================================================
// vecmac_accum
// ----------------------------------------------------------------------------
// Downstream reduction and accumulation stage for the 4-lane 8x8 unsigned
// multiplier. Each accepted beat carries four 16-bit lane products. The stage
// adds them into one 18-bit beat sum in a register stage (S1). It then adds
// that sum into a saturating accumulator over cfg_len beats and presents one
// dot-product result per vector on a valid/ready output.
//
// Handshake semantics (input and output sides alike):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   valid never depends on ready. On the output side, out_valid/out_acc/out_ovf
//   stay stable while out_valid && !out_ready. On the input side, in_ready is
//   a pure function of internal state and out_ready, and never of in_valid.
//   A beat presented while in_ready is low is discarded, and the sticky
//   drop_err flag records that it happened.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_len    beats per vector; sampled only when a vector starts; 0 acts as 1
//   in_valid   product beat valid
//   in_ready   stage can take a beat this cycle
//   product    {p3,p2,p1,p0}, four 16-bit unsigned lane products (p0 = [15:0])
//   out_valid  dot-product result valid
//   out_ready  consumer accepts the result
//   out_acc    dot-product result (saturating, ACC_W bits)
//   out_ovf    result saturated; qualified by out_valid
//   drop_err   sticky: a beat arrived while in_ready was low
//   dbg_state  current FSM state (IDLE=0, ACC=1, DONE=2) for observation
// ============================================================================
module vecmac_accum #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              drop_err,
  output logic [1:0]        dbg_state
);

  // Four 16-bit lanes sum to at most 4*65025 = 260100, so 18 bits always fit.
  localparam int SUM_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  // S1 register stage: one reduced beat waiting for the accumulator.
  logic               s1_valid;
  logic [SUM_W-1:0]   s1_sum;

  // Accumulator datapath.
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic               ovf;
  logic               drop_q;

  // Combinational helpers.
  logic               stall;
  logic               accept;
  logic               consume;
  logic               start_vec;
  logic               step_vec;
  logic [SUM_W-1:0]   lane_sum;
  logic [LEN_W-1:0]   cfg_eff;
  logic [ACC_W:0]     sum_ext;
  logic               sat;

  // --------------------------------------------------------------------------
  // Beat reduction: zero-extend each lane before adding so no carry is lost.
  // --------------------------------------------------------------------------
  assign lane_sum = {2'b00, product[15:0]}
                  + {2'b00, product[31:16]}
                  + {2'b00, product[47:32]}
                  + {2'b00, product[63:48]};

  // A finished result that the consumer is refusing blocks the accumulator.
  // The S1 beat sitting behind it must then be held. A new beat can only be
  // taken while S1 is still free.
  assign stall    = (state_q == DONE) && !out_ready;
  assign in_ready = !(s1_valid && stall);
  assign accept   = in_valid && in_ready;
  assign consume  = s1_valid && !stall;

  // A zero length would never terminate, so it runs as a single-beat vector.
  assign cfg_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  // One extra bit on the adder exposes the carry that signals saturation.
  assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, s1_sum};
  assign sat      = sum_ext[ACC_W];

  // --------------------------------------------------------------------------
  // FSM next-state and control strobes.
  // start_vec : load acc with the S1 beat and open a new vector.
  // step_vec  : fold the S1 beat into the running vector.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start_vec = 1'b0;
    step_vec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s1_valid) begin
          start_vec = 1'b1;
          state_d   = (cfg_eff == LEN_W'(1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (s1_valid) begin
          step_vec = 1'b1;
          // cnt counts beats already folded in; this beat is number cnt+1.
          if ((cnt + LEN_W'(1)) == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (s1_valid) begin
            // The result leaves this cycle and the waiting beat opens the
            // next vector immediately, so there is no bubble between vectors.
            start_vec = 1'b1;
            state_d   = (cfg_eff == LEN_W'(1)) ? DONE : ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, S1 stage and accumulator registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= LEN_W'(1);
      ovf      <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // S1: a new beat overwrites only a slot that is free or being drained.
      // Otherwise the slot empties when consumed, or holds while stalled.
      if (accept) begin
        s1_valid <= 1'b1;
        s1_sum   <= lane_sum;
      end else if (consume) begin
        s1_valid <= 1'b0;
      end

      if (in_valid && !in_ready) begin
        drop_q <= 1'b1;
      end

      if (start_vec) begin
        acc   <= {{(ACC_W - SUM_W){1'b0}}, s1_sum};
        cnt   <= LEN_W'(1);
        len_q <= cfg_eff;
        ovf   <= 1'b0;
      end else if (step_vec) begin
        cnt <= cnt + LEN_W'(1);
        if (sat) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= sum_ext[ACC_W-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The result is driven straight from the accumulator. acc only
  // changes on start_vec/step_vec, and neither fires in DONE unless
  // out_ready is high, so the result stays stable while stalled.
  // --------------------------------------------------------------------------
  assign out_valid = (state_q == DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;
  assign drop_err  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: doc/vecmac_accum.md
Name: vecmac_accum

Overview:
- Downstream stage of the 4-lane 8x8 unsigned multiplier.
- Consumes the multiplier's packed 4x16-bit product word and reduces the four lane products to one sum each beat.
- Accumulates that sum over a programmable number of beats, producing one unsigned dot-product result per vector.
- Result is presented on a valid/ready output handshake; a one-entry hold stage absorbs the beat in flight when the output stalls.

Parameters:
- ACC_W, 32, accumulator and result width in bits; saturating.
- LEN_W, 16, width of the beats-per-vector configuration.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_len  input  LEN_W  beats per vector; 0 is treated as 1.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- product  input  64  {p3,p2,p1,p0}, each 16-bit unsigned; p0 = bits 15:0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_acc  output  ACC_W  dot-product result.
- out_ovf  output  1  result saturated; valid with out_valid.
- drop_err  output  1  sticky: a beat arrived with in_ready low; cleared only by rst.

Behaviour:
- Reset: state IDLE, s1_valid=0, acc=0, cnt=0, out_valid=0, out_acc=0, out_ovf=0, drop_err=0. in_ready=1 in the cycle after reset.
- S1 register stage:
  - On the in_valid && in_ready edge, s1_sum <= p0+p1+p2+p3, zero-extended.
  - s1_sum is 18 bits (max 260100 < 2^18), so it never overflows.
  - s1_valid holds its value while state==DONE and out_ready==0.
- in_ready = !(s1_valid && state==DONE && !out_ready). Combinational; no dependency on in_valid.
- in_valid with in_ready==0: beat discarded, drop_err <= 1.
- FSM:
  - IDLE: on s1_valid, acc <= s1_sum, cnt <= 1, len_q <= max(cfg_len,1), out_ovf <= 0. Next state is DONE if len_q==1, else ACC.
  - ACC: on s1_valid, acc <= sat(acc+s1_sum) and cnt++. Go to DONE when cnt+1 == len_q. No s1_valid: hold state.
  - DONE: out_valid=1, out_acc=acc.
    - out_ready && s1_valid: start the next vector in the same cycle, with the same actions as IDLE. Zero-bubble back-to-back.
    - out_ready && !s1_valid: go to IDLE.
    - !out_ready: hold; out_acc and out_ovf stable.
- Saturation:
  - If acc+s1_sum >= 2^ACC_W, acc <= 2^ACC_W-1 and out_ovf <= 1.
  - Once set, out_ovf stays set until the next vector starts.
- Latency: a beat accepted at edge t updates acc at edge t+1. For len=1, out_valid is high after edge t+1, i.e. 2 cycles after in_valid is presented.
- cfg_len is sampled only at vector start. Changing it mid-vector has no effect on the current vector.
- rst mid-vector: partial sum, count, s1 beat and pending result are all discarded. The next accepted beat starts a fresh vector.
- Throughput: one beat per cycle whenever out_ready is high or no result is pending.

Test Plan:
- Single beat: cfg_len=1, product=0x0004_0003_0002_0001 → out_valid 2 cycles after in_valid, out_acc=10, out_ovf=0.
- Four beats: cfg_len=4, four beats of all lanes 0xFE01 → one result, out_acc=0x000FE010 (1040400); no out_valid earlier.
- Back-to-back: cfg_len=2 with continuous beats of lane sums 1,2,3,4 → results 3 then 7 on consecutive vectors, out_ready=1, no idle cycles.
- Backpressure:
  - cfg_len=1, out_ready=0, three consecutive beats (sums 5,6,7).
  - Expected: result 5 held stable; in_ready falls when beat 6 is in S1; beat 7 is dropped and drop_err=1.
  - Raise out_ready: results 5 then 6 delivered, no 7.
- Saturation: cfg_len=65535, all beats 0xFE01 per lane (total 17045653500) → out_acc=0xFFFFFFFF, out_ovf=1. The next vector, cfg_len=1 with sum 10, gives out_acc=10, out_ovf=0.
- Reset and zero length:
  - cfg_len=8, 3 beats, then rst for 1 cycle → out_valid=0, drop_err=0.
  - Then cfg_len=0 and one beat of sum 9 → treated as len 1, out_acc=9.
